// File: rtl/piradip_tdp_ram_bw.sv
// True dual-port RAM with per-byte write enables, one shared clock, a
// configurable read pipeline and same-address collision detection/counting.
// Memory contents are never reset; only the read pipelines and collision
// status are cleared by resetn.
module piradip_tdp_ram_bw #(
  parameter int                    DATA_WIDTH         = 32,
  parameter int                    ADDR_WIDTH         = 10,
  parameter int                    BYTE_WIDTH         = 8,
  parameter int                    READ_LATENCY       = 2,
  parameter string                 WRITE_MODE_A       = "no_change",
  parameter string                 WRITE_MODE_B       = "no_change",
  parameter string                 COLLISION_PRIORITY = "A",
  parameter logic [DATA_WIDTH-1:0] READ_RESET_VALUE   = '0,
  localparam int                   NB                 = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  a_en,
  input  logic [NB-1:0]         a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic [NB-1:0]         b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic                  collision,
  output logic [15:0]           collision_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] M_NC = 2'd0;
  localparam logic [1:0] M_RF = 2'd1;
  localparam logic [1:0] M_WF = 2'd2;

  localparam logic [1:0] MODE_A = (WRITE_MODE_A == "read_first")  ? M_RF :
                                  (WRITE_MODE_A == "write_first") ? M_WF : M_NC;
  localparam logic [1:0] MODE_B = (WRITE_MODE_B == "read_first")  ? M_RF :
                                  (WRITE_MODE_B == "write_first") ? M_WF : M_NC;

  // Port index 0 is A, 1 is B; HP wins bytes written by both ports.
  localparam int HP = (COLLISION_PRIORITY == "B") ? 1 : 0;
  localparam int LP = 1 - HP;

  if ((DATA_WIDTH % BYTE_WIDTH) != 0 || READ_LATENCY < 1 || READ_LATENCY > 4 ||
      !(WRITE_MODE_A == "read_first" || WRITE_MODE_A == "write_first" ||
        WRITE_MODE_A == "no_change") ||
      !(WRITE_MODE_B == "read_first" || WRITE_MODE_B == "write_first" ||
        WRITE_MODE_B == "no_change") ||
      !(COLLISION_PRIORITY == "A" || COLLISION_PRIORITY == "B")) begin : g_param_error
    $error("piradip_tdp_ram_bw: illegal parameter combination");
  end

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            en_p;
  logic [1:0]            wr_p;
  logic [NB-1:0]         we_p    [2];
  logic [ADDR_WIDTH-1:0] addr_p  [2];
  logic [DATA_WIDTH-1:0] wdata_p [2];

  assign en_p       = {b_en, a_en};
  assign wr_p       = {b_en && (b_we != '0), a_en && (a_we != '0)};
  assign we_p[0]    = a_we;
  assign we_p[1]    = b_we;
  assign addr_p[0]  = a_addr;
  assign addr_p[1]  = b_addr;
  assign wdata_p[0] = a_wdata;
  assign wdata_p[1] = b_wdata;

  logic                  same_addr;
  logic                  coll;
  logic [DATA_WIDTH-1:0] old_w   [2];
  logic [DATA_WIDTH-1:0] fin_w   [2];
  logic [1:0]            ret;
  logic [DATA_WIDTH-1:0] ret_dat [2];

  // Pre-write words, final stored words (with byte arbitration) and per-port return data.
  always_comb begin
    logic [DATA_WIDTH-1:0] both_w;
    logic [1:0]            mode;
    same_addr = en_p[0] && en_p[1] && (addr_p[0] == addr_p[1]);
    coll      = same_addr && (wr_p != 2'b00);
    for (int p = 0; p < 2; p++) begin
      old_w[p] = mem[addr_p[p]];
      fin_w[p] = wr_p[p] ? merge_bytes(old_w[p], wdata_p[p], we_p[p]) : old_w[p];
    end
    both_w = merge_bytes(merge_bytes(old_w[LP], wdata_p[LP], we_p[LP]), wdata_p[HP], we_p[HP]);
    if (same_addr && wr_p[0] && wr_p[1]) begin
      fin_w[0] = both_w;
      fin_w[1] = both_w;
    end
    for (int p = 0; p < 2; p++) begin
      mode       = (p == 0) ? MODE_A : MODE_B;
      ret[p]     = en_p[p] && (!wr_p[p] || mode != M_NC);
      ret_dat[p] = (wr_p[p] && mode == M_WF) ? fin_w[p] : old_w[p];
    end
  end

  // Storage update; both ports carry the same merged word when they collide.
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int p = 0; p < 2; p++)
        if (wr_p[p]) mem[addr_p[p]] <= fin_w[p];
    end
  end

  logic                  vld_q [2][READ_LATENCY];
  logic [DATA_WIDTH-1:0] dat_q [2][READ_LATENCY];

  // Read pipelines; a stage's data only moves with a valid entry so the last stage holds.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int p = 0; p < 2; p++)
        for (int k = 0; k < READ_LATENCY; k++) begin
          vld_q[p][k] <= 1'b0;
          dat_q[p][k] <= READ_RESET_VALUE;
        end
    end else begin
      for (int p = 0; p < 2; p++) begin
        vld_q[p][0] <= ret[p];
        if (ret[p]) dat_q[p][0] <= ret_dat[p];
        for (int k = 1; k < READ_LATENCY; k++) begin
          vld_q[p][k] <= vld_q[p][k-1];
          if (vld_q[p][k-1]) dat_q[p][k] <= dat_q[p][k-1];
        end
      end
    end
  end

  assign a_rvalid = vld_q[0][READ_LATENCY-1];
  assign a_rdata  = dat_q[0][READ_LATENCY-1];
  assign b_rvalid = vld_q[1][READ_LATENCY-1];
  assign b_rdata  = dat_q[1][READ_LATENCY-1];

  // Collision pulse and saturating collision counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      collision       <= 1'b0;
      collision_count <= 16'h0000;
    end else begin
      collision <= coll;
      if (coll && collision_count != 16'hFFFF) collision_count <= collision_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_piradip_tdp_ram_bw.sv
// Bench for piradip_tdp_ram_bw: a read_first/write_first instance driven by
// directed and random traffic against a word-level memory model, plus a
// default (no_change) instance for byte-write and pipelining scenarios.
module tb_piradip_tdp_ram_bw;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int NB = 4;
  localparam int L  = 2;

  logic clk = 1'b0;
  logic resetn;

  logic          a_en, b_en, a_rvalid, b_rvalid, collision;
  logic [NB-1:0] a_we, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic [15:0]   collision_count;

  logic          n_a_en, n_b_en, n_a_rvalid, n_b_rvalid, n_collision;
  logic [NB-1:0] n_a_we, n_b_we;
  logic [AW-1:0] n_a_addr, n_b_addr;
  logic [DW-1:0] n_a_wdata, n_b_wdata, n_a_rdata, n_b_rdata;
  logic [15:0]   n_collision_count;

  always #5 clk = ~clk;

  piradip_tdp_ram_bw #(
    .WRITE_MODE_A("read_first"),
    .WRITE_MODE_B("write_first")
  ) dut (
    .clk(clk), .resetn(resetn),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .collision(collision), .collision_count(collision_count)
  );

  piradip_tdp_ram_bw dut_nc (
    .clk(clk), .resetn(resetn),
    .a_en(n_a_en), .a_we(n_a_we), .a_addr(n_a_addr), .a_wdata(n_a_wdata),
    .a_rdata(n_a_rdata), .a_rvalid(n_a_rvalid),
    .b_en(n_b_en), .b_we(n_b_we), .b_addr(n_b_addr), .b_wdata(n_b_wdata),
    .b_rdata(n_b_rdata), .b_rvalid(n_b_rvalid),
    .collision(n_collision), .collision_count(n_collision_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          qa[$];
  exp_t          qb[$];
  logic [DW-1:0] mm [1 << AW];
  logic [DW-1:0] last_a = '0;
  logic [DW-1:0] last_b = '0;
  logic          exp_coll = 1'b0;
  logic [15:0]   exp_cnt = 16'h0000;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [NB-1:0] we);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++)
      if (we[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  // One cycle on the main instance: check what the previous edges produced,
  // then drive the next access and predict its effect.
  task automatic step(input logic rn,
                      input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aa,
                      input logic [DW-1:0] awd,
                      input logic be, input logic [NB-1:0] bwe, input logic [AW-1:0] ba,
                      input logic [DW-1:0] bwd);
    logic          ev;
    logic          a_wr, b_wr;
    logic [DW-1:0] oa, ob;
    exp_t          e;
    @(negedge clk);
    cyc++;
    ev = (qa.size() > 0) && (qa[0].due == cyc);
    if (ev) begin e = qa.pop_front(); last_a = e.d; end
    check("a_rvalid", a_rvalid, ev);
    check("a_rdata", a_rdata, last_a);
    ev = (qb.size() > 0) && (qb[0].due == cyc);
    if (ev) begin e = qb.pop_front(); last_b = e.d; end
    check("b_rvalid", b_rvalid, ev);
    check("b_rdata", b_rdata, last_b);
    check("collision", collision, exp_coll);
    check("collision_count", collision_count, exp_cnt);

    resetn = rn;
    a_en = ae; a_we = awe; a_addr = aa; a_wdata = awd;
    b_en = be; b_we = bwe; b_addr = ba; b_wdata = bwd;

    if (!rn) begin
      qa.delete(); qb.delete();
      last_a = '0; last_b = '0; exp_coll = 1'b0; exp_cnt = 16'h0000;
    end else begin
      a_wr = ae && (awe != '0);
      b_wr = be && (bwe != '0);
      oa = mm[aa];
      ob = mm[ba];
      if (b_wr) mm[ba] = merge(mm[ba], bwd, bwe);
      if (a_wr) mm[aa] = merge(mm[aa], awd, awe);  // A has priority, so it lands last
      if (ae) begin e.due = cyc + L; e.d = oa; qa.push_back(e); end
      if (be) begin e.due = cyc + L; e.d = b_wr ? mm[ba] : ob; qb.push_back(e); end
      exp_coll = ae && be && (aa == ba) && (a_wr || b_wr);
      if (exp_coll && exp_cnt != 16'hFFFF) exp_cnt++;
    end
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
  endtask

  task automatic nc_drive(input logic ae, input logic [NB-1:0] awe, input logic [AW-1:0] aa,
                          input logic [DW-1:0] awd, input logic be, input logic [AW-1:0] ba);
    n_a_en = ae; n_a_we = awe; n_a_addr = aa; n_a_wdata = awd;
    n_b_en = be; n_b_we = 4'h0; n_b_addr = ba; n_b_wdata = '0;
  endtask

  initial begin
    logic [AW-1:0] ra, rb;
    logic [NB-1:0] rwa, rwb;
    resetn = 1'b0;
    a_en = 1'b0; a_we = '0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_wdata = '0;
    nc_drive(1'b0, 4'h0, '0, '0, 1'b0, '0);
    repeat (3) @(negedge clk);

    check("rst a_rvalid", a_rvalid, 1'b0);
    check("rst a_rdata", a_rdata, 32'h0);
    check("rst b_rvalid", b_rvalid, 1'b0);
    check("rst b_rdata", b_rdata, 32'h0);
    check("rst collision", collision, 1'b0);
    check("rst count", collision_count, 16'h0);
    check("rst nc a_rdata", n_a_rdata, 32'h0);
    resetn = 1'b1;

    // Default instance: byte write, no_change writes, pipelined reads.
    nc_drive(1'b1, 4'hF, 10'd5, 32'h11223344, 1'b0, '0);
    @(negedge clk);
    nc_drive(1'b1, 4'b0010, 10'd5, 32'hAABBCCDD, 1'b0, '0);
    @(negedge clk);
    nc_drive(1'b0, 4'h0, '0, '0, 1'b1, 10'd5);
    @(negedge clk);
    nc_drive(1'b0, 4'h0, '0, '0, 1'b0, '0);
    check("nc b_rvalid early", n_b_rvalid, 1'b0);
    check("nc a_rvalid write", n_a_rvalid, 1'b0);
    check("nc a_rdata write", n_a_rdata, 32'h0);
    @(negedge clk);
    check("bytewr b_rvalid", n_b_rvalid, 1'b1);
    check("bytewr b_rdata", n_b_rdata, 32'h1122CC44);
    @(negedge clk);
    check("bytewr b_rvalid end", n_b_rvalid, 1'b0);
    check("bytewr b_rdata hold", n_b_rdata, 32'h1122CC44);
    for (int i = 0; i < 8; i++) begin
      nc_drive(1'b1, 4'hF, AW'(i), DW'(i), 1'b0, '0);
      @(negedge clk);
      check("nc fill a_rvalid", n_a_rvalid, 1'b0);
    end
    for (int m = 0; m < 12; m++) begin
      if (m >= 1) begin
        check("pipe a_rvalid", n_a_rvalid, (m >= 2 && m <= 9) ? 1'b1 : 1'b0);
        if (m >= 2) check("pipe a_rdata", n_a_rdata, (m <= 9) ? 32'(m - 2) : 32'd7);
      end
      if (m < 8) nc_drive(1'b1, 4'h0, AW'(m), '0, 1'b0, '0);
      else       nc_drive(1'b0, 4'h0, '0, '0, 1'b0, '0);
      @(negedge clk);
    end

    // Main instance: preload a small address pool through B (write_first).
    for (int i = 0; i < 17; i++) begin
      ra = (i == 16) ? AW'(1023) : AW'(i);
      step(1'b1, 1'b0, 4'h0, '0, '0, 1'b1, 4'hF, ra,
           (i == 2) ? 32'd7 : (i == 3) ? 32'd1 : 32'hC0DE0000 + 32'(i));
    end
    repeat (3) idle();

    // read_first on A, write_first on B.
    step(1'b1, 1'b1, 4'hF, 10'd3, 32'd2, 1'b0, 4'h0, '0, '0);
    step(1'b1, 1'b0, 4'h0, '0, '0, 1'b1, 4'hF, 10'd3, 32'd2);
    idle();
    check("rf a_rvalid", a_rvalid, 1'b1);
    check("rf a_rdata", a_rdata, 32'd1);
    idle();
    check("wf b_rdata", b_rdata, 32'd2);

    // Write/write collision, A priority.
    step(1'b1, 1'b1, 4'hF, 10'd9, 32'hFFFF0000, 1'b1, 4'h3, 10'd9, 32'h0000FFFF);
    idle();
    check("ww collision", collision, 1'b1);
    check("ww count", collision_count, 16'd1);
    idle();
    check("ww b final", b_rdata, 32'hFFFF0000);
    check("ww pulse end", collision, 1'b0);

    // Read/write collision: reader sees the old word.
    step(1'b1, 1'b1, 4'h0, 10'd2, '0, 1'b1, 4'hF, 10'd2, 32'd8);
    idle();
    check("rw collision", collision, 1'b1);
    check("rw count", collision_count, 16'd2);
    idle();
    check("rw a old", a_rdata, 32'd7);
    step(1'b1, 1'b1, 4'h0, 10'd2, '0, 1'b0, 4'h0, '0, '0);
    idle(); idle();
    check("rw a new", a_rdata, 32'd8);

    // Reset with reads in flight.
    step(1'b1, 1'b1, 4'h0, 10'd0, '0, 1'b1, 4'h0, 10'd1, '0);
    step(1'b0, 1'b1, 4'h0, 10'd1, '0, 1'b0, 4'h0, '0, '0);
    idle();
    check("mid-rst a_rvalid", a_rvalid, 1'b0);
    check("mid-rst a_rdata", a_rdata, 32'h0);
    check("mid-rst count", collision_count, 16'h0);
    idle();
    check("mid-rst b_rvalid", b_rvalid, 1'b0);
    step(1'b1, 1'b1, 4'h0, 10'd9, '0, 1'b0, 4'h0, '0, '0);
    idle(); idle();
    check("mem kept", a_rdata, 32'hFFFF0000);

    // Random traffic over the preloaded pool.
    for (int n = 0; n < 500; n++) begin
      ra  = ($urandom_range(0, 16) == 16) ? AW'(1023) : AW'($urandom_range(0, 15));
      rb  = ($urandom_range(0, 3) == 0) ? ra :
            ($urandom_range(0, 16) == 16) ? AW'(1023) : AW'($urandom_range(0, 15));
      rwa = ($urandom_range(0, 1) == 1) ? NB'($urandom) : 4'h0;
      rwb = ($urandom_range(0, 1) == 1) ? NB'($urandom) : 4'h0;
      step(($urandom_range(0, 29) != 0), 1'($urandom), rwa, ra, DW'($urandom),
           1'($urandom), rwb, rb, DW'($urandom));
    end
    repeat (4) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
